// File: rtl/uart_rx_cmd_parser_if.sv
// Bundle between the UART receiver byte stream and the parser's register-file / ALU strobes.
interface uart_rx_cmd_parser_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic [7:0]        P_data;
   logic              data_valid;
   logic              par_err;
   logic              stp_err;
   logic              RF_WrEn;
   logic              RF_RdEn;
   logic [ADDR_W-1:0] RF_Address;
   logic [7:0]        RF_WrData;
   logic              ALU_EN;
   logic [3:0]        ALU_FUN;
   logic              busy;
   logic              cmd_err;

   // Receiver / controller side
   modport master (
      output P_data, data_valid, par_err, stp_err,
      input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, busy, cmd_err
   );

   // Parser side
   modport slave (
      input  P_data, data_valid, par_err, stp_err,
      output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, busy, cmd_err
   );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// Decodes write / read / ALU command frames from received UART bytes into single-cycle
// register-file and ALU strobes, aborting on line errors or inter-byte timeout.
module uart_rx_cmd_parser #(
   parameter int unsigned ADDR_W  = 4,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input logic                 CLK,
   input logic                 RST,
   uart_rx_cmd_parser_if.slave bus
);
   typedef enum logic [2:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StRdAddr,
      StAluA,
      StAluB,
      StAluFun
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [3:0]        alu_fun_q, alu_fun_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              alu_en_q, alu_en_d;
   logic              cmd_err_q, cmd_err_d;
   logic              line_err, byte_ok, timed_out;

   assign line_err  = bus.par_err | bus.stp_err;
   // A byte flagged with a line error is never consumed.
   assign byte_ok   = bus.data_valid & ~line_err;
   assign timed_out = (state_q != StIdle) && (cnt_q == TIMEOUT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rf_addr_d = rf_addr_q;
      wr_data_d = wr_data_q;
      alu_fun_d = alu_fun_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      cmd_err_d = 1'b0;

      if (state_q == StIdle) begin
         cnt_d = '0;
         if (byte_ok) begin
            case (bus.P_data)
               8'hAA:   state_d = StWrAddr;
               8'hBB:   state_d = StRdAddr;
               8'hCC:   state_d = StAluA;
               8'hDD:   state_d = StAluFun;
               default: cmd_err_d = 1'b1;
            endcase
         end
      end else if (line_err || timed_out) begin
         state_d   = StIdle;
         cnt_d     = '0;
         cmd_err_d = 1'b1;
      end else if (byte_ok) begin
         cnt_d = '0;
         case (state_q)
            StWrAddr: begin
               addr_d  = bus.P_data[ADDR_W-1:0];
               state_d = StWrData;
            end
            StWrData: begin
               wr_en_d   = 1'b1;
               rf_addr_d = addr_q;
               wr_data_d = bus.P_data;
               state_d   = StIdle;
            end
            StRdAddr: begin
               rd_en_d   = 1'b1;
               addr_d    = bus.P_data[ADDR_W-1:0];
               rf_addr_d = bus.P_data[ADDR_W-1:0];
               state_d   = StIdle;
            end
            // Operands land in registers 0 and 1 ahead of the ALU start.
            StAluA: begin
               wr_en_d   = 1'b1;
               rf_addr_d = '0;
               wr_data_d = bus.P_data;
               state_d   = StAluB;
            end
            StAluB: begin
               wr_en_d   = 1'b1;
               rf_addr_d = ADDR_W'(1);
               wr_data_d = bus.P_data;
               state_d   = StAluFun;
            end
            StAluFun: begin
               alu_en_d  = 1'b1;
               alu_fun_d = bus.P_data[3:0];
               state_d   = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         rf_addr_q <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rf_addr_q <= rf_addr_d;
         wr_data_q <= wr_data_d;
         alu_fun_q <= alu_fun_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         alu_en_q  <= alu_en_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   assign bus.RF_WrEn    = wr_en_q;
   assign bus.RF_RdEn    = rd_en_q;
   assign bus.RF_Address = rf_addr_q;
   assign bus.RF_WrData  = wr_data_q;
   assign bus.ALU_EN     = alu_en_q;
   assign bus.ALU_FUN    = alu_fun_q;
   assign bus.cmd_err    = cmd_err_q;
   assign bus.busy       = (state_q != StIdle);
endmodule
